// File: rtl/shared_wire_arb_pkg.sv
// Shared types and sizing helpers for the shared-wire round-robin arbiter.
package shared_wire_arb_pkg;

  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_MAX_HOLD   = 16;
  localparam int unsigned DEF_TURNAROUND = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Bits needed for a saturating counter that must reach max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
module rr_pick
  import shared_wire_arb_pkg::*;
#(
  parameter int unsigned N = DEF_N_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate so that ptr lands on bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  // Undo the rotation modulo N.
  assign sum = {1'b0, off} + {1'b0, ptr};
  assign idx = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N))
                                        : sum[IDX_W-1:0];

endmodule

// File: rtl/shared_wire_arbiter.sv
// Round-robin owner scheduler for a shared tristate wire with hold limit and
// enforced idle turnaround between owners.
module shared_wire_arbiter
  import shared_wire_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD,
  parameter int unsigned TURNAROUND = DEF_TURNAROUND
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     timeout
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned HOLD_W = cnt_width(MAX_HOLD);
  localparam int unsigned TURN_W = cnt_width(TURNAROUND);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic              timeout_q, timeout_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_req;
  logic              hold_full;
  logic              release_now;
  logic              turn_last;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req   = req[owner_q];
  assign hold_full   = (hold_q == HOLD_W'(MAX_HOLD));
  assign release_now = !owner_req || hold_full;
  assign turn_last   = (turn_q == TURN_W'(TURNAROUND));

  // State and registered outputs; reset drops gnt without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      turn_q    <= '0;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   if (release_now) state_d = TURN;
      TURN:    if (turn_last) state_d = pick_valid ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of counters, pointer and registered outputs.
  always_comb begin
    hold_d    = hold_q;
    turn_d    = turn_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE, TURN: begin
        if (state_q == TURN && !turn_last) begin
          turn_d = turn_q + 1'b1;
        end else if (pick_valid) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          busy_d  = 1'b1;
          owner_d = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          turn_d    = TURN_W'(1);
          timeout_d = owner_req;
          rr_ptr_d  = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign owner_id = owner_q;
  assign timeout  = timeout_q;

endmodule
